// File: rtl/msg_stream_pkg.sv
// msg_stream_pkg: ROM image, message tables and FSM state type shared by msg_stream_rom.
package msg_stream_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    localparam int ROM_DEPTH = 64;
    localparam int MAX_MSG   = 8;

    localparam logic [7:0] ROM_IMAGE [ROM_DEPTH] = '{
        8'h00, 8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45, 8'h45,
        8'h52, 8'h49, 8'h4E, 8'h47, 8'h20, 8'h41, 8'h53, 8'h53,
        8'h49, 8'h47, 8'h4E, 8'h4D, 8'h45, 8'h4E, 8'h54, 8'h20,
        8'h53, 8'h54, 8'h55, 8'h44, 8'h45, 8'h4E, 8'h54, 8'h20,
        8'h46, 8'h50, 8'h47, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Entries past the four real messages are empty so NUM_MSG up to MAX_MSG is legal.
    localparam int MSG_BASE [MAX_MSG] = '{1, 13, 24, 32, 0, 0, 0, 0};
    localparam int MSG_LEN  [MAX_MSG] = '{11, 10, 7, 4, 0, 0, 0, 0};

    function automatic logic [7:0] rom_word(input int a);
        return (a >= 0 && a < ROM_DEPTH) ? ROM_IMAGE[a[5:0]] : 8'h00;
    endfunction

    function automatic int msg_base(input int s);
        return (s >= 0 && s < MAX_MSG) ? MSG_BASE[s[2:0]] : 0;
    endfunction

    function automatic int msg_len(input int s);
        return (s >= 0 && s < MAX_MSG) ? MSG_LEN[s[2:0]] : 0;
    endfunction
endpackage

// File: rtl/msg_char_rom.sv
// msg_char_rom: synchronous-read character ROM holding ROM_IMAGE.
module msg_char_rom
    import msg_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk)
        data <= DATA_W'(rom_word(int'(addr)));
endmodule

// File: rtl/msg_stream_rom.sv
// msg_stream_rom: streams a selected ROM message one character per beat over valid/ready,
// with looping, abort, and done/err status pulses.
module msg_stream_rom
    import msg_stream_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int NUM_MSG = 4,
    parameter int SEL_W   = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              loop_en,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n, addr;
    logic [ADDR_W:0]   len, len_n, idx, idx_n;
    logic              done_n, err_n, last;
    logic [DATA_W-1:0] rom_q;
    int                sel_i, tbl_len;

    assign sel_i   = int'(msg_sel);
    assign tbl_len = msg_len(sel_i);
    assign addr    = base + idx[ADDR_W-1:0];
    assign last    = idx == len - 1'b1;

    msg_char_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_q)
    );

    always_comb begin
        state_n = state;
        base_n  = base;
        len_n   = len;
        idx_n   = idx;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (sel_i >= NUM_MSG) err_n = 1'b1;
                else if (tbl_len == 0) done_n = 1'b1;
                else begin
                    base_n  = ADDR_W'(msg_base(sel_i));
                    len_n   = (ADDR_W+1)'(tbl_len);
                    idx_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = abort ? IDLE : SEND;
            SEND: if (abort) state_n = IDLE;
            else if (out_ready) begin
                idx_n   = last ? '0 : idx + 1'b1;
                state_n = (last && !loop_en) ? IDLE : FETCH;
                done_n  = last && !loop_en;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
            len   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            base  <= base_n;
            len   <= len_n;
            idx   <= idx_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // ROM data has no reset, so the character bus is forced to zero outside SEND.
    assign out_valid = state == SEND;
    assign out_last  = out_valid && last;
    assign out_data  = out_valid ? rom_q : '0;
    assign busy      = state != IDLE;
endmodule
